// File: rtl/bi_set_sequencer.sv
// BiSet bus master: queued read/write burst commands expanded into single-cycle bus beats,
// with a streamed write-data port and a credit-protected read response FIFO.
module bi_set_sequencer #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RDEPTH = 4,
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned LW     = $clog2(MAXLEN)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic          cmd_inc_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic          wdata_valid_i,
  output logic          wdata_ready_o,
  input  logic [DW-1:0] wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_last_o,
  output logic          set_en_o,
  output logic          set_we_o,
  output logic [AW-1:0] set_addr_o,
  output logic [DW-1:0] set_wdata_o,
  input  logic [DW-1:0] set_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CPW = $clog2(DEPTH);
  localparam int unsigned RPW = $clog2(RDEPTH);
  localparam int unsigned CW  = 2 + AW + LW;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  // Command FIFO
  logic [CW-1:0] cmd_mem [DEPTH];
  logic [CPW:0]  cmd_wptr_q, cmd_rptr_q;
  logic          cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic [CW-1:0] cmd_head;

  // Engine
  logic [0:0]    state_q, state_d;
  logic          we_q, we_d, inc_q, inc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          fire, rd_inflight, rd_credit_ok;

  // Bus registers
  logic          set_en_q, set_we_q, beat_last_q;
  logic [AW-1:0] set_addr_q;
  logic [DW-1:0] set_wdata_q;

  // Response FIFO
  logic [DW:0]   rsp_mem [RDEPTH];
  logic [RPW:0]  rsp_wptr_q, rsp_rptr_q, rsp_count;
  logic          rsp_empty, rsp_pop;
  logic [DW:0]   rsp_head;

  assign cmd_empty   = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full    = (cmd_wptr_q[CPW] != cmd_rptr_q[CPW]) &&
                       (cmd_wptr_q[CPW-1:0] == cmd_rptr_q[CPW-1:0]);
  assign cmd_ready_o = !cmd_full;
  assign cmd_push    = cmd_valid_i && !cmd_full;
  assign cmd_pop     = (state_q == StIdle) && !cmd_empty;
  assign cmd_head    = cmd_mem[cmd_rptr_q[CPW-1:0]];

  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem[cmd_wptr_q[CPW-1:0]] <= {cmd_we_i, cmd_inc_i, cmd_addr_i, cmd_len_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
    end else begin
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
    end
  end

  // A read on the bus this cycle is already owed a response slot.
  assign rd_inflight  = set_en_q && !set_we_q;
  assign rsp_count    = rsp_wptr_q - rsp_rptr_q;
  assign rd_credit_ok = ({1'b0, rsp_count} + {{(RPW + 1){1'b0}}, rd_inflight})
                        < (RPW + 2)'(RDEPTH);
  assign fire         = (state_q == StBurst) && (we_q ? wdata_valid_i : rd_credit_ok);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    inc_d   = inc_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (!cmd_empty) begin
          {we_d, inc_d, addr_d, rem_d} = cmd_head;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (fire) begin
          addr_d = addr_q + AW'(inc_q);
          rem_d  = rem_q - LW'(1);
          if (rem_q == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      inc_q       <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      set_en_q    <= 1'b0;
      set_we_q    <= 1'b0;
      set_addr_q  <= '0;
      set_wdata_q <= '0;
      beat_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      inc_q       <= inc_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      set_en_q    <= fire;
      set_we_q    <= fire && we_q;
      set_addr_q  <= fire ? addr_q : '0;
      set_wdata_q <= (fire && we_q) ? wdata_i : '0;
      beat_last_q <= fire && (rem_q == '0);
    end
  end

  assign set_en_o      = set_en_q;
  assign set_we_o      = set_we_q;
  assign set_addr_o    = set_addr_q;
  assign set_wdata_o   = set_wdata_q;
  assign wdata_ready_o = (state_q == StBurst) && we_q;
  assign busy_o        = !cmd_empty || (state_q == StBurst) || rd_inflight;

  // Read reply is captured at the edge closing the beat's bus cycle.
  always_ff @(posedge clk_i) begin
    if (rd_inflight) rsp_mem[rsp_wptr_q[RPW-1:0]] <= {beat_last_q, set_rdata_i};
  end

  assign rsp_empty   = (rsp_wptr_q == rsp_rptr_q);
  assign rsp_valid_o = !rsp_empty;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign rsp_head    = rsp_mem[rsp_rptr_q[RPW-1:0]];
  assign rsp_data_o  = rsp_valid_o ? rsp_head[DW-1:0] : '0;
  assign rsp_last_o  = rsp_valid_o && rsp_head[DW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
    end else begin
      if (rd_inflight) rsp_wptr_q <= rsp_wptr_q + 1'b1;
      if (rsp_pop)     rsp_rptr_q <= rsp_rptr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_bi_set_sequencer.sv
// Scoreboard bench for bi_set_sequencer: expected bus beats and read responses are queued at
// stimulus time and consumed by a monitor whenever the DUT presents them.
module tb_bi_set_sequencer;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_inc_i;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic          wdata_valid_i, wdata_ready_o;
  logic [DW-1:0] wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_last_o;
  logic [DW-1:0] rsp_data_o;
  logic          set_en_o, set_we_o;
  logic [AW-1:0] set_addr_o;
  logic [DW-1:0] set_wdata_o, set_rdata_i;
  logic          busy_o;

  bi_set_sequencer #(
    .AW(AW), .DW(DW), .DEPTH(4), .RDEPTH(4), .MAXLEN(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_inc_i(cmd_inc_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_last_o(rsp_last_o), .set_en_o(set_en_o), .set_we_o(set_we_o),
    .set_addr_o(set_addr_o), .set_wdata_o(set_wdata_o), .set_rdata_i(set_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Target model: replies with the inverted address during a read beat's bus cycle.
  assign set_rdata_i = (set_en_o && !set_we_o) ? {{(DW - AW){1'b0}}, ~set_addr_o} : '0;

  logic [AW+DW:0] exp_beats [$];  // {we, addr, wdata}
  logic [DW:0]    exp_rsps  [$];  // {last, data}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_beat(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_beats.push_back({we, a, d});
  endtask

  task automatic push_rsp(input logic last, input logic [DW-1:0] d);
    exp_rsps.push_back({last, d});
  endtask

  task automatic monitor();
    logic [AW+DW:0] b;
    logic [DW:0]    r;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (set_en_o) begin
          if (exp_beats.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", set_addr_o);
          end else begin
            b = exp_beats.pop_front();
            chk("beat", {31'd0, set_we_o, set_addr_o, set_wdata_o}, {31'd0, b});
          end
        end
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_rsps.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data 0x%0h, expected no response", rsp_data_o);
          end else begin
            r = exp_rsps.pop_front();
            chk("rsp", {31'd0, rsp_last_o, rsp_data_o}, {31'd0, r});
          end
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_en"}, set_en_o, 0);
    chk({tag, "_we"}, set_we_o, 0);
    chk({tag, "_addr"}, set_addr_o, 0);
    chk({tag, "_wdata"}, set_wdata_o, 0);
    chk({tag, "_wrdy"}, wdata_ready_o, 0);
    chk({tag, "_rvalid"}, rsp_valid_o, 0);
    chk({tag, "_rlast"}, rsp_last_o, 0);
    chk({tag, "_rdata"}, rsp_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_crdy"}, cmd_ready_o, 1);
  endtask

  task automatic issue(input logic we, input logic inc, input logic [AW-1:0] a,
                       input logic [LW-1:0] len);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_inc_i   = inc;
    cmd_addr_i  = a;
    cmd_len_i   = len;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_rsps.size() != 0 || busy_o || rsp_valid_o)
           && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, (n < budget), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    int k;
    int accepted;
    logic rdy;

    rst_i = 1'b1;
    cmd_valid_i = 0; cmd_we_i = 0; cmd_inc_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_valid_i = 0; wdata_i = '0; rsp_ready_i = 0;
    fork
      monitor();
    join_none
    #1;
    check_idle("rst");
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check_idle("post_rst");

    // Single write, data presented before the command
    wdata_valid_i = 1'b1;
    wdata_i = 32'hDEADBEEF;
    push_beat(1'b1, 16'h0010, 32'hDEADBEEF);
    issue(1'b1, 1'b1, 16'h0010, 4'd0);
    chk("wr1_after_e0", set_en_o, 0);
    tick();
    chk("wr1_after_e1", set_en_o, 0);
    tick();
    chk("wr1_after_e2", set_en_o, 1);
    wdata_valid_i = 1'b0;
    tick();
    chk("wr1_single", set_en_o, 0);
    chk("wr1_busy", busy_o, 0);

    // Incrementing read burst wrapping the address space
    rsp_ready_i = 1'b1;
    push_beat(1'b0, 16'hFFFE, '0);
    push_beat(1'b0, 16'hFFFF, '0);
    push_beat(1'b0, 16'h0000, '0);
    push_beat(1'b0, 16'h0001, '0);
    push_rsp(1'b0, 32'h0000_0001);
    push_rsp(1'b0, 32'h0000_0000);
    push_rsp(1'b0, 32'h0000_FFFF);
    push_rsp(1'b1, 32'h0000_FFFE);
    issue(1'b0, 1'b1, 16'hFFFE, 4'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_b2b", set_en_o, 1);
    end
    tick();
    chk("rd_end", set_en_o, 0);
    wait_drain("rd", 20);

    // Response back-pressure limits beats to RDEPTH
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_beat(1'b0, 16'h0040, '0);
      push_rsp(i == 7, 32'h0000_FFBF);
    end
    issue(1'b0, 1'b0, 16'h0040, 4'd7);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_beat", set_en_o, 1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_stall", set_en_o, 0);
    end
    chk("bp_rvalid", rsp_valid_o, 1);
    chk("bp_pending", exp_beats.size(), 4);
    rsp_ready_i = 1'b1;
    wait_drain("bp", 40);

    // Write burst with gaps in the data stream
    pat = 7'b1011001;
    for (int i = 0; i < 4; i++) push_beat(1'b1, 16'h0100 + 16'(i), 32'hC0DE0000 + 32'(i));
    issue(1'b1, 1'b1, 16'h0100, 4'd3);
    tick();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      wdata_valid_i = pat[i];
      wdata_i = 32'hC0DE0000 + 32'(k);
      chk("gap_wrdy", wdata_ready_o, 1);
      tick();
      chk("gap_en", set_en_o, pat[i]);
      if (pat[i]) k++;
    end
    wdata_valid_i = 1'b0;
    wait_drain("gap", 10);

    // Command FIFO fills while the engine stalls on write data
    accepted = 0;
    cmd_valid_i = 1'b1;
    cmd_we_i = 1'b1;
    cmd_inc_i = 1'b1;
    cmd_len_i = 4'd0;
    cmd_addr_i = 16'h0200;
    wdata_i = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      rdy = cmd_ready_o;
      tick();
      if (rdy) begin
        push_beat(1'b1, cmd_addr_i, 32'h12345678);
        accepted++;
        cmd_addr_i = 16'h0200 + 16'(accepted);
      end
    end
    chk("full_accepted", accepted, 5);
    chk("full_rdy", cmd_ready_o, 0);
    wdata_valid_i = 1'b1;
    tick();
    wdata_valid_i = 1'b0;
    chk("full_pop_rdy", cmd_ready_o, 0);
    tick();
    chk("no_push_when_full", cmd_ready_o, 1);
    cmd_valid_i = 1'b0;
    wdata_valid_i = 1'b1;
    wait_drain("full", 40);
    wdata_valid_i = 1'b0;

    // Reset in the middle of a read burst
    for (int i = 0; i < 3; i++) push_beat(1'b0, 16'h0300 + 16'(i), '0);
    push_rsp(1'b0, 32'h0000_FCFF);
    push_rsp(1'b0, 32'h0000_FCFE);
    issue(1'b0, 1'b1, 16'h0300, 4'd7);
    for (int i = 0; i < 5; i++) tick();
    rst_i = 1'b1;
    #1;
    check_idle("mid_rst");
    chk("mid_rst_beats_left", exp_beats.size(), 0);
    chk("mid_rst_rsps_left", exp_rsps.size(), 0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    chk("no_stale_rsp", rsp_valid_o, 0);
    push_beat(1'b0, 16'h0ABC, '0);
    push_rsp(1'b1, 32'h0000_F543);
    issue(1'b0, 1'b1, 16'h0ABC, 4'd0);
    wait_drain("fresh", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
